// File: rtl/ldw_fetch_pkg.sv
// ldw_fetch_pkg
// Shared constants for the instruction-fetch front end.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   INST_W           : instruction word width
//   PC_STEP          : sequential PC increment, in bytes
//   NOP_INST         : encoding used for empty instruction slots
package ldw_fetch_pkg;

    localparam logic [31:0]       RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int                INST_W           = 32;
    localparam int                PC_STEP          = 4;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

endpackage

// File: rtl/ldw_fetch_hold.sv
// ldw_fetch_hold
// Single-entry skid register sitting between the instruction memory response
// and the IF/ID register. It parks a response that decode refused, and
// selects either the parked entry or the live memory response as the output.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   rsp_v             : a memory response is present this cycle
//   rsp_pc, rsp_inst  : PC and data of that response
//   id_ready          : decode accepts the presented instruction
//   redirect_valid    : redirect this cycle; drops anything parked
//   hold_v            : the skid entry holds an instruction
//   sel_pc, sel_inst  : instruction presented downstream
module ldw_fetch_hold
    import ldw_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsp_v,
    input  logic [ADDR_W-1:0] rsp_pc,
    input  logic [INST_W-1:0] rsp_inst,
    input  logic              id_ready,
    input  logic              redirect_valid,
    output logic              hold_v,
    output logic [ADDR_W-1:0] sel_pc,
    output logic [INST_W-1:0] sel_inst
);

    logic [ADDR_W-1:0] hold_pc;
    logic [INST_W-1:0] hold_inst;
    logic              capture;
    logic              clear;

    // The memory read data is only valid for one cycle, so a refused response
    // must be copied here or it is lost. A redirect makes it dead anyway.
    assign capture = rsp_v & ~id_ready & ~redirect_valid;
    assign clear   = id_ready | redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_pc   <= '0;
            hold_inst <= NOP_INST;
        end else if (clear) begin
            hold_v <= 1'b0;
        end else if (capture) begin
            hold_v    <= 1'b1;
            hold_pc   <= rsp_pc;
            hold_inst <= rsp_inst;
        end
    end

    // The issue logic never lets a new response arrive while an entry is
    // parked, so the parked entry always takes priority without conflict.
    always_comb begin
        if (hold_v) begin
            sel_pc   = hold_pc;
            sel_inst = hold_inst;
        end else begin
            sel_pc   = rsp_pc;
            sel_inst = rsp_inst;
        end
    end

endmodule

// File: rtl/ldw_fetch.sv
// ldw_fetch
// Instruction-fetch front end. Drives the word address to a synchronous
// instruction memory (one cycle read latency), pairs the returned word with
// its PC, absorbs decode backpressure with a one-entry skid register and
// handles branch/jump redirects with a single bubble.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_en        : allow new fetches to be issued
//   redirect_valid  : taken branch/jump this cycle
//   redirect_pc     : redirect target (low two bits ignored)
//   imem_addr       : byte address presented to the instruction memory
//   imem_inst       : memory data for the address presented last cycle
//   if_valid        : if_pc/if_inst carry a live instruction
//   if_pc, if_inst  : delivered instruction and its PC
//   id_ready        : decode accepts; transfer on if_valid & id_ready
module ldw_fetch
    import ldw_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    input  logic              id_ready
);

    logic [ADDR_W-1:0] pc_q;
    logic              req_v;
    logic [ADDR_W-1:0] req_pc;
    logic              hold_v;
    logic              rsp_v;
    logic              out_v;
    logic              issue;

    assign rsp_v = req_v;
    assign out_v = hold_v | rsp_v;

    // The redirect cycle itself delivers nothing: whatever is on the output
    // belongs to the wrong path.
    assign if_valid = out_v & ~redirect_valid;

    // Redirect targets go straight to the memory so the target's data is
    // back the very next cycle.
    assign imem_addr = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00} : pc_q;

    // A new fetch is only issued when its response has somewhere to go: the
    // output is empty, or the current output is being consumed this cycle.
    assign issue = redirect_valid | (fetch_en & (~out_v | id_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            req_v  <= 1'b0;
            req_pc <= '0;
        end else if (issue) begin
            req_v  <= 1'b1;
            req_pc <= imem_addr;
            pc_q   <= imem_addr + ADDR_W'(PC_STEP);
        end else begin
            req_v <= 1'b0;
        end
    end

    ldw_fetch_hold #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk            (clk),
        .rst_n          (rst_n),
        .rsp_v          (rsp_v),
        .rsp_pc         (req_pc),
        .rsp_inst       (imem_inst),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .hold_v         (hold_v),
        .sel_pc         (if_pc),
        .sel_inst       (if_inst)
    );

endmodule
